// File: rtl/shifter_result_buffer_if.sv
// Handshake and status bundle between the shifter, the result buffer and
// the ALU writeback path. master = the side that feeds/consumes the buffer,
// slave = the buffer itself.
interface shifter_result_buffer_if #(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH),
    parameter int DEPTH              = 4
);
    localparam int LEVEL_WIDTH = $clog2(DEPTH + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_WIDTH-1:0]         in_data;
    logic [SHIFT_AMOUNT_WIDTH-1:0] in_shift_amount;
    logic [1:0]                    in_shift_op;
    logic [DATA_WIDTH-1:0]         in_result;

    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_result;
    logic                          out_zero;
    logic                          out_neg;
    logic                          out_carry;
    logic                          out_illegal;

    logic [LEVEL_WIDTH-1:0]        level;
    logic                          full;
    logic                          empty;

    modport master (
        output in_valid, in_data, in_shift_amount, in_shift_op, in_result,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_zero, out_neg, out_carry, out_illegal,
        input  level, full, empty
    );

    modport slave (
        input  in_valid, in_data, in_shift_amount, in_shift_op, in_result,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_zero, out_neg, out_carry, out_illegal,
        output level, full, empty
    );
endinterface

// File: rtl/shifter_result_buffer.sv
// Registered output stage behind the combinational shifter. Derives status
// flags at push time and queues {result, zero, neg, carry, illegal} in a
// DEPTH-entry FIFO presented to writeback with valid/ready.
// DEPTH must be a power of two and at least 2 so the pointers wrap freely.
module shifter_result_buffer #(
    parameter int DATA_WIDTH         = 8,
    parameter int SHIFT_AMOUNT_WIDTH = $clog2(DATA_WIDTH),
    parameter int DEPTH              = 4
) (
    input logic                 clk,
    input logic                 rst,
    shifter_result_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  zero;
        logic                  neg;
        logic                  carry;
        logic                  illegal;
    } entry_t;

    entry_t                        mem [DEPTH];
    entry_t                        new_entry;
    entry_t                        head;
    logic [PTR_W-1:0]              wr_ptr;
    logic [PTR_W-1:0]              rd_ptr;
    logic [LVL_W-1:0]              level_q;
    logic                          full_w;
    logic                          empty_w;
    logic                          push;
    logic                          pop;
    logic [SHIFT_AMOUNT_WIDTH-1:0] sll_idx;
    logic [SHIFT_AMOUNT_WIDTH-1:0] srl_idx;

    // Status depends only on the registered level, never on same-cycle handshakes.
    assign full_w  = (level_q == LVL_W'(DEPTH));
    assign empty_w = (level_q == '0);
    assign push    = bus.in_valid && !full_w;
    assign pop     = bus.out_ready && !empty_w;

    // Bit that left the word last: for SLL it sits at DATA_WIDTH-amt, for
    // SRL/SRA at amt-1. Only used when amt != 0.
    assign sll_idx = SHIFT_AMOUNT_WIDTH'(DATA_WIDTH - int'(bus.in_shift_amount));
    assign srl_idx = bus.in_shift_amount - SHIFT_AMOUNT_WIDTH'(1);

    // Build the entry to be stored from the upstream operands and result.
    always_comb begin
        new_entry         = '0;
        new_entry.result  = bus.in_result;
        new_entry.zero    = (bus.in_result == '0);
        new_entry.neg     = bus.in_result[DATA_WIDTH-1];
        new_entry.illegal = (bus.in_shift_op == 2'b11);
        new_entry.carry   = 1'b0;
        if (bus.in_shift_amount != '0) begin
            case (bus.in_shift_op)
                2'b00:        new_entry.carry = bus.in_data[sll_idx];
                2'b01, 2'b10: new_entry.carry = bus.in_data[srl_idx];
                default:      new_entry.carry = 1'b0;
            endcase
        end
    end

    // Storage is not cleared on reset; empty masking hides stale contents.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

    // Head entry, forced to zero while the queue is empty.
    always_comb begin
        head = empty_w ? '0 : mem[rd_ptr];
    end

    assign bus.in_ready    = !full_w;
    assign bus.out_valid   = !empty_w;
    assign bus.out_result  = head.result;
    assign bus.out_zero    = head.zero;
    assign bus.out_neg     = head.neg;
    assign bus.out_carry   = head.carry;
    assign bus.out_illegal = head.illegal;
    assign bus.level       = level_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
endmodule

// File: tb/tb_shifter_result_buffer.sv
// Directed bench for shifter_result_buffer (DATA_WIDTH=8, DEPTH=4).
module tb_shifter_result_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    shifter_result_buffer_if #(.DATA_WIDTH(8), .SHIFT_AMOUNT_WIDTH(3), .DEPTH(4)) bus ();

    shifter_result_buffer #(.DATA_WIDTH(8), .SHIFT_AMOUNT_WIDTH(3), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_in(input logic v, input logic [7:0] d, input logic [2:0] a,
                            input logic [1:0] op, input logic [7:0] r);
        bus.in_valid        = v;
        bus.in_data         = d;
        bus.in_shift_amount = a;
        bus.in_shift_op     = op;
        bus.in_result       = r;
    endtask

    function automatic logic [3:0] flags();
        return {bus.out_zero, bus.out_neg, bus.out_carry, bus.out_illegal};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_result !== 8'h00) begin errors++; $display("FAIL reset_out_result got %h want 00", bus.out_result); end
        checks++; if (flags() !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags()); end
    endtask

    // Push one entry, check head result/flags one cycle later, then pop it.
    task automatic test_one(input string name, input logic [7:0] d, input logic [2:0] a,
                            input logic [1:0] op, input logic [7:0] r,
                            input logic [3:0] exp_flags);
        drive_in(1'b1, d, a, op, r);
        bus.out_ready = 1'b0;
        step();
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b want 1", name, bus.out_valid); end
        checks++; if (bus.out_result !== r) begin errors++; $display("FAIL %s_result got %h want %h", name, bus.out_result, r); end
        checks++; if (flags() !== exp_flags) begin errors++; $display("FAIL %s_flags got %b want %b", name, flags(), exp_flags); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.empty !== 1'b1 || bus.out_result !== 8'h00 || flags() !== 4'b0000)
            begin errors++; $display("FAIL %s_drain empty=%b result=%h flags=%b want 1/00/0000", name, bus.empty, bus.out_result, flags()); end
    endtask

    task automatic test_flags();
        // flags order: zero neg carry illegal
        test_one("sll_0f_1",  8'h0F, 3'd1, 2'b00, 8'h1E, 4'b0000);
        test_one("sra_8f_1",  8'h8F, 3'd1, 2'b10, 8'hC7, 4'b0110);
        test_one("sll_aa_7",  8'hAA, 3'd7, 2'b00, 8'h00, 4'b1010);
        test_one("op11_55",   8'h12, 3'd3, 2'b11, 8'h55, 4'b0001);
        test_one("srl_amt0",  8'h81, 3'd0, 2'b01, 8'h81, 4'b0100);
        test_one("srl_02_2",  8'h02, 3'd2, 2'b01, 8'h00, 4'b1010);
    endtask

    task automatic test_full();
        logic [7:0] exp_seq [4];
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'(i));
            step();
        end
        checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", bus.level); end
        checks++; if (bus.full !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_flags full=%b in_ready=%b want 1/0", bus.full, bus.in_ready); end
        drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'h05);
        step();
        checks++; if (bus.level !== 3'd4 || bus.out_result !== 8'h01) begin errors++; $display("FAIL full_hold level=%0d head=%h want 4/01", bus.level, bus.out_result); end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.level !== 3'd3 || bus.out_result !== 8'h02 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL full_pop1 level=%0d head=%h in_ready=%b want 3/02/1", bus.level, bus.out_result, bus.in_ready); end
        step();
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        checks++; if (bus.level !== 3'd3 || bus.out_result !== 8'h03) begin errors++; $display("FAIL full_accept5 level=%0d head=%h want 3/03", bus.level, bus.out_result); end
        exp_seq[0] = 8'h04; exp_seq[1] = 8'h05;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.out_result !== exp_seq[i] || bus.level !== 3'(2 - i))
                begin errors++; $display("FAIL full_drain%0d head=%h level=%0d want %h/%0d", i, bus.out_result, bus.level, exp_seq[i], 2 - i); end
        end
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_final_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'h10);
        step();
        drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'h11);
        step();
        checks++; if (bus.level !== 3'd2 || bus.out_result !== 8'h10) begin errors++; $display("FAIL b2b_start level=%0d head=%h want 2/10", bus.level, bus.out_result); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'(8'h11 + k));
            step();
            checks++; if (bus.level !== 3'd2 || bus.out_result !== 8'(8'h10 + k))
                begin errors++; $display("FAIL b2b_cycle%0d level=%0d head=%h want 2/%h", k, bus.level, bus.out_result, 8'(8'h10 + k)); end
        end
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        step();
        checks++; if (bus.level !== 3'd1 || bus.out_result !== 8'h17) begin errors++; $display("FAIL b2b_tail level=%0d head=%h want 1/17", bus.level, bus.out_result); end
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty got %b want 1", bus.empty); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'(8'hA0 + i));
            step();
        end
        checks++; if (bus.level !== 3'd3) begin errors++; $display("FAIL rmid_level3 got %0d want 3", bus.level); end
        rst = 1'b1;
        drive_in(1'b1, 8'hFF, 3'd1, 2'b00, 8'hEE);
        step();
        rst = 1'b0;
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        checks++; if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
            begin errors++; $display("FAIL rmid_state level=%0d out_valid=%b in_ready=%b want 0/0/1", bus.level, bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_result !== 8'h00 || flags() !== 4'b0000) begin errors++; $display("FAIL rmid_outputs result=%h flags=%b want 00/0000", bus.out_result, flags()); end
        step();
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rmid_dropped empty=%b want 1", bus.empty); end
        drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'h77);
        step();
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        checks++; if (bus.level !== 3'd1 || bus.out_result !== 8'h77) begin errors++; $display("FAIL rmid_repush level=%0d head=%h want 1/77", bus.level, bus.out_result); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_underflow();
        bus.out_ready = 1'b1;
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.level !== 3'd0 || bus.empty !== 1'b1 || bus.out_valid !== 1'b0)
                begin errors++; $display("FAIL uflow%0d level=%0d empty=%b out_valid=%b want 0/1/0", i, bus.level, bus.empty, bus.out_valid); end
        end
        drive_in(1'b1, 8'h00, 3'd0, 2'b00, 8'h33);
        step();
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        checks++; if (bus.level !== 3'd1 || bus.out_result !== 8'h33) begin errors++; $display("FAIL uflow_push level=%0d head=%h want 1/33", bus.level, bus.out_result); end
        step();
        checks++; if (bus.level !== 3'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL uflow_pop level=%0d empty=%b want 0/1", bus.level, bus.empty); end
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.out_ready = 1'b0;
        drive_in(1'b0, 8'h00, 3'd0, 2'b00, 8'h00);
        #2;
        test_reset();
        test_flags();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_underflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
